float_round: RTL

Parametrised IEEE-754 round-to-integral unit that generalises the existing single-precision `trunc` block. It takes a binary floating-point operand plus a per-operand rounding mode and returns the integral value in the same float format. The four supported modes are truncate, floor, ceil and round-half-even. It sits in the float component library behind the same stb/ack stream handshake as the other arithmetic blocks, and is fully pipelined with backpressure.

---
 rtl/float_pkg.sv | 18 +
 rtl/float_round_decide.sv | 41 ++++
 rtl/float_round.sv | 73 +++++++
 3 files changed

// File: rtl/float_pkg.sv
// float_pkg: rounding-mode codes, result selects and field helpers shared by the float library
package float_pkg;
   localparam logic [1:0] RND_TRUNC   = 2'd0;
   localparam logic [1:0] RND_FLOOR   = 2'd1;
   localparam logic [1:0] RND_CEIL    = 2'd2;
   localparam logic [1:0] RND_NEAREST = 2'd3;
   localparam int FLD_MAX = 64;
   typedef enum logic [1:0] {SEL_GEN, SEL_PASS, SEL_ZERO, SEL_ONE} sel_t;
   function automatic logic fld_sign(input logic [FLD_MAX-1:0] a, input int exp_w, input int man_w);
      return |(a & (FLD_MAX'(1) << (exp_w + man_w)));
   endfunction
   function automatic logic [FLD_MAX-1:0] fld_exp(input logic [FLD_MAX-1:0] a, input int exp_w, input int man_w);
      return (a >> man_w) & ((FLD_MAX'(1) << exp_w) - FLD_MAX'(1));
   endfunction
   function automatic logic [FLD_MAX-1:0] fld_man(input logic [FLD_MAX-1:0] a, input int man_w);
      return a & ((FLD_MAX'(1) << man_w) - FLD_MAX'(1));
   endfunction
endpackage

// File: rtl/float_round_decide.sv
// float_round_decide: fractional mask, increment decision and special-case select for one operand
module float_round_decide import float_pkg::*; #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic             s,
   input  logic [EXP_W-1:0] e,
   input  logic [MAN_W-1:0] m,
   input  logic [1:0]       mode,
   output logic [MAN_W-1:0] mask,
   output logic             inc,
   output sel_t             sel
);
   localparam int UE_W = EXP_W + 2;
   localparam int SH_W = $clog2(MAN_W + 1);
   localparam logic signed [UE_W-1:0] BIAS = UE_W'((1 << (EXP_W - 1)) - 1);
   localparam logic signed [UE_W-1:0] MANS = UE_W'(MAN_W);
   logic signed [UE_W-1:0] ue;
   logic [SH_W-1:0] sh;
   logic [MAN_W:0] lsb_bit;
   logic nz, frac_nz, guard, sticky, lsb, tiny_one;
   // unbiased exponent selects the case; the mask marks the bits below the binary point
   always_comb begin
      ue = $signed({2'b00, e}) - BIAS;
      sh = SH_W'(MANS - ue);
      mask = ~({MAN_W{1'b1}} << sh);
      lsb_bit = {mask, 1'b1} & ~{1'b0, mask};
      nz = |{e, m};
      frac_nz = |(m & mask);
      guard = |(m & mask & ~(mask >> 1));
      sticky = |(m & (mask >> 1));
      lsb = |({e[0], m} & lsb_bit);
      tiny_one = mode == RND_NEAREST ? (&ue) & (|m) :
                 mode == RND_FLOOR   ? s & nz :
                 mode == RND_CEIL    ? !s & nz : 1'b0;
      inc = mode == RND_NEAREST ? guard & (sticky | lsb) :
            mode == RND_FLOOR   ? s & frac_nz :
            mode == RND_CEIL    ? !s & frac_nz : 1'b0;
      sel = ue >= MANS ? SEL_PASS : ue[UE_W-1] ? (tiny_one ? SEL_ONE : SEL_ZERO) : SEL_GEN;
   end
endmodule

// File: rtl/float_round.sv
// float_round: two-stage pipelined round-to-integral with stb/ack handshake and backpressure
module float_round #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [EXP_W+MAN_W:0]   input_a,
   input  logic [1:0]             input_mode,
   input  logic                   input_a_stb,
   output logic                   input_a_ack,
   output logic [EXP_W+MAN_W:0]   output_z,
   output logic                   output_z_stb,
   input  logic                   output_z_ack
);
   import float_pkg::*;
   localparam int W = 1 + EXP_W + MAN_W;
   localparam int F = EXP_W + MAN_W;
   localparam logic [EXP_W-1:0] BIAS = EXP_W'((1 << (EXP_W - 1)) - 1);
   logic [FLD_MAX-1:0] a_ext;
   logic a_s, d_inc, s1_v, s1_s, s1_inc, s2_v, s1_ld, s2_ld;
   logic [EXP_W-1:0] a_e, s1_e;
   logic [MAN_W-1:0] a_m, d_mask, s1_m, s1_mask;
   sel_t d_sel, s1_sel;
   logic [F-1:0] fld, add;
   logic [W-1:0] z_nxt, s2_z;
   assign a_ext = FLD_MAX'(input_a);
   assign a_s = fld_sign(a_ext, EXP_W, MAN_W);
   assign a_e = EXP_W'(fld_exp(a_ext, EXP_W, MAN_W));
   assign a_m = MAN_W'(fld_man(a_ext, MAN_W));
   float_round_decide #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_decide (
      .s(a_s), .e(a_e), .m(a_m), .mode(input_mode), .mask(d_mask), .inc(d_inc), .sel(d_sel)
   );
   assign s2_ld = !s2_v | output_z_ack;
   assign s1_ld = !s1_v | s2_ld;
   assign input_a_ack = s1_ld;
   assign output_z = s2_z;
   assign output_z_stb = s2_v;
   assign fld = {s1_e, s1_m};
   assign add = s1_inc ? F'(s1_mask) + F'(1) : '0;
   assign z_nxt = s1_sel == SEL_PASS ? {s1_s, fld} :
                  s1_sel == SEL_ZERO ? {s1_s, F'(0)} :
                  s1_sel == SEL_ONE  ? {s1_s, BIAS, MAN_W'(0)} :
                  {s1_s, (fld & ~F'(s1_mask)) + add};
   // S1 holds the decoded operand with its rounding decision
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         s1_v <= 1'b0;
         s1_s <= 1'b0;
         s1_e <= '0;
         s1_m <= '0;
         s1_mask <= '0;
         s1_inc <= 1'b0;
         s1_sel <= SEL_GEN;
      end else if (s1_ld) begin
         s1_v <= input_a_stb;
         s1_s <= a_s;
         s1_e <= a_e;
         s1_m <= a_m;
         s1_mask <= d_mask;
         s1_inc <= d_inc;
         s1_sel <= d_sel;
      end
   // S2 holds the assembled result and freezes while the consumer stalls
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         s2_v <= 1'b0;
         s2_z <= '0;
      end else if (s2_ld) begin
         s2_v <= s1_v;
         s2_z <= z_nxt;
      end
endmodule
